// File: rtl/hilo_result_unit.sv
// HI/LO result holder: captures the high/low words of one selected multi-cycle
// arithmetic unit, supports direct MTHI/MTLO writes, and aborts a stalled wait by watchdog.
module hilo_result_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NSRC    = 2,
    parameter int unsigned SEL_W   = 1,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SEL_W-1:0]      op_sel,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC*WIDTH-1:0] src_hi,
    input  logic [NSRC*WIDTH-1:0] src_lo,
    input  logic                  wr_hi,
    input  logic                  wr_lo,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      hi_out,
    output logic [WIDTH-1:0]      lo_out,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state, next_state;
    logic [SEL_W-1:0]   sel_q, next_sel;
    logic [CNT_W-1:0]   cnt, next_cnt;
    logic [WIDTH-1:0]   next_hi, next_lo;
    logic               abort;
    logic               sel_valid;
    logic [WIDTH-1:0]   sel_hi, sel_lo;

    always_comb begin
        sel_valid = 1'b0;
        sel_hi    = '0;
        sel_lo    = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (32'(sel_q) == i) begin
                sel_valid = src_valid[i];
                sel_hi    = src_hi[i*WIDTH +: WIDTH];
                sel_lo    = src_lo[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        next_state = state;
        next_sel   = sel_q;
        next_cnt   = cnt;
        next_hi    = hi_out;
        next_lo    = lo_out;
        abort      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (wr_hi) next_hi = wr_data;
                if (wr_lo) next_lo = wr_data;
                if (start && (32'(op_sel) < NSRC)) begin
                    next_sel   = op_sel;
                    next_cnt   = '0;
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // A valid arriving on the final watchdog cycle still commits.
                if (sel_valid) begin
                    next_hi    = sel_hi;
                    next_lo    = sel_lo;
                    next_state = S_DONE;
                end else if (cnt >= CNT_LAST) begin
                    abort      = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            sel_q       <= '0;
            cnt         <= '0;
            hi_out      <= '0;
            lo_out      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= next_state;
            sel_q       <= next_sel;
            cnt         <= next_cnt;
            hi_out      <= next_hi;
            lo_out      <= next_lo;
            busy        <= (next_state == S_WAIT);
            done        <= (next_state == S_DONE);
            timeout_err <= abort;
        end
    end

endmodule
